// File: rtl/mem_access_ctrl.sv
// Load/store controller between a CPU request port and a word-wide memory.
// Handles lane selection, store replication, load extension, alignment errors and ack timeout.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_addr_lo;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [29:0] r_mem_addr;
    logic [3:0]  r_mem_sel;
    logic [31:0] r_mem_wdata;

    logic        w_misaligned;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    always_comb begin
        w_misaligned = 1'b0;
        w_sel        = 4'b1111;
        w_wdata      = req_wdata;
        case (req_size)
            2'b00: begin
                w_sel   = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_misaligned = req_addr[0];
                w_sel        = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata      = {2{req_wdata[15:0]}};
            end
            2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b1;
        endcase
    end

    // Load lane is picked from the registered low address bits, not the live request.
    always_comb begin
        case (r_addr_lo)
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_we         <= 1'b0;
            r_addr_lo    <= 2'b00;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_ready      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 30'd0;
            r_mem_sel    <= 4'd0;
            r_mem_wdata  <= 32'd0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (req_valid && r_ready) begin
                        r_ready   <= 1'b0;
                        r_we      <= req_we;
                        r_addr_lo <= req_addr[1:0];
                        r_size    <= req_size;
                        r_signed  <= req_signed;
                        if (w_misaligned) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state     <= ACCESS;
                            r_cnt       <= 8'd0;
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= req_we;
                            r_mem_addr  <= req_addr[31:2];
                            r_mem_sel   <= w_sel;
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                ACCESS: begin
                    // An ack arriving in the final allowed cycle still wins over the timeout.
                    if (mem_ack || r_cnt == 8'(TIMEOUT - 1)) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= !mem_ack;
                        r_resp_rdata <= (mem_ack && !r_we) ? w_load : 32'd0;
                        r_mem_en     <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= 30'd0;
                        r_mem_sel    <= 4'd0;
                        r_mem_wdata  <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_sel    = r_mem_sel;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT = 4.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    int vecCount  = 0;
    int missCount = 0;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request in an IDLE cycle and returns in the first cycle after the accept edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        vecCount++; if (req_ready !== 1'b0) begin missCount++; $display("[TB] FAIL reset_ready: got %b expected 0", req_ready); end
        vecCount++; if ({mem_en, resp_valid, resp_err} !== 3'b000) begin missCount++; $display("[TB] FAIL reset_outs: got %b expected 000", {mem_en, resp_valid, resp_err}); end
        vecCount++; if ({mem_sel, mem_addr, mem_wdata, resp_rdata} !== 98'd0) begin missCount++; $display("[TB] FAIL reset_buses: got %h expected 0", {mem_sel, mem_addr, mem_wdata, resp_rdata}); end
        rst_n = 1'b1;
        vecCount++; if (req_ready !== 1'b0) begin missCount++; $display("[TB] FAIL release_ready_early: got %b expected 0", req_ready); end
        step();
        vecCount++; if (req_ready !== 1'b1) begin missCount++; $display("[TB] FAIL release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_byte_store();
        issue(1'b1, 32'h0000_1002, 2'b00, 1'b0, 32'h0000_00AB);
        vecCount++; if ({mem_en, mem_we, req_ready} !== 3'b110) begin missCount++; $display("[TB] FAIL bst_ctrl: got %b expected 110", {mem_en, mem_we, req_ready}); end
        vecCount++; if (mem_sel !== 4'b0100) begin missCount++; $display("[TB] FAIL bst_sel: got %b expected 0100", mem_sel); end
        vecCount++; if (mem_wdata !== 32'hABAB_ABAB) begin missCount++; $display("[TB] FAIL bst_wdata: got %h expected ababab ab", mem_wdata); end
        vecCount++; if (mem_addr !== 30'h400) begin missCount++; $display("[TB] FAIL bst_addr: got %h expected 400", mem_addr); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        vecCount++; if ({resp_valid, resp_err, mem_en} !== 3'b100) begin missCount++; $display("[TB] FAIL bst_resp: got %b expected 100", {resp_valid, resp_err, mem_en}); end
        vecCount++; if (resp_rdata !== 32'd0) begin missCount++; $display("[TB] FAIL bst_rdata: got %h expected 0", resp_rdata); end
        vecCount++; if (req_ready !== 1'b0) begin missCount++; $display("[TB] FAIL bst_ready_in_resp: got %b expected 0", req_ready); end
        step();
        vecCount++; if ({resp_valid, req_ready} !== 2'b01) begin missCount++; $display("[TB] FAIL bst_done: got %b expected 01", {resp_valid, req_ready}); end
    endtask

    // One load with ack in the first ACCESS cycle; checks lane select and the extended result.
    task automatic test_loads();
        logic [31:0] addrs [4]  = '{32'h0000_0006, 32'h0000_0006, 32'h0000_0001, 32'h0000_0008};
        logic [1:0]  sizes [4]  = '{2'b01, 2'b01, 2'b00, 2'b10};
        logic        sgns  [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] rdats [4]  = '{32'h8001_1234, 32'h8001_1234, 32'h0000_F500, 32'hDEAD_BEEF};
        logic [3:0]  sels  [4]  = '{4'b1100, 4'b1100, 4'b0010, 4'b1111};
        logic [31:0] exps  [4]  = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FFF5, 32'hDEAD_BEEF};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, addrs[i], sizes[i], sgns[i], 32'h0);
            vecCount++; if ({mem_en, mem_we, mem_sel} !== {2'b10, sels[i]}) begin missCount++; $display("[TB] FAIL load%0d_sel: got %b expected %b", i, {mem_en, mem_we, mem_sel}, {2'b10, sels[i]}); end
            vecCount++; if (mem_addr !== addrs[i][31:2]) begin missCount++; $display("[TB] FAIL load%0d_addr: got %h expected %h", i, mem_addr, addrs[i][31:2]); end
            mem_rdata = rdats[i];
            mem_ack   = 1'b1;
            step();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            vecCount++; if ({resp_valid, resp_err} !== 2'b10) begin missCount++; $display("[TB] FAIL load%0d_resp: got %b expected 10", i, {resp_valid, resp_err}); end
            vecCount++; if (resp_rdata !== exps[i]) begin missCount++; $display("[TB] FAIL load%0d_rdata: got %h expected %h", i, resp_rdata, exps[i]); end
            step();
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0000};
        logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1;
            issue(1'b0, addrs[i], sizes[i], 1'b0, 32'h0);
            vecCount++; if ({mem_en, resp_valid, resp_err} !== 3'b011) begin missCount++; $display("[TB] FAIL mis%0d_resp: got %b expected 011", i, {mem_en, resp_valid, resp_err}); end
            vecCount++; if (resp_rdata !== 32'd0) begin missCount++; $display("[TB] FAIL mis%0d_rdata: got %h expected 0", i, resp_rdata); end
            step();
            mem_ack = 1'b0;
            vecCount++; if ({mem_en, resp_valid, req_ready} !== 3'b001) begin missCount++; $display("[TB] FAIL mis%0d_after: got %b expected 001", i, {mem_en, resp_valid, req_ready}); end
        end
    endtask

    task automatic test_timeout();
        int enCycles = 0;
        issue(1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0);
        for (int i = 0; i < 12 && resp_valid !== 1'b1; i++) begin
            if (mem_en === 1'b1) enCycles++;
            step();
        end
        vecCount++; if (enCycles != 4) begin missCount++; $display("[TB] FAIL timeout_en_cycles: got %0d expected 4", enCycles); end
        vecCount++; if ({resp_valid, resp_err, mem_en} !== 3'b110) begin missCount++; $display("[TB] FAIL timeout_resp: got %b expected 110", {resp_valid, resp_err, mem_en}); end
        vecCount++; if (resp_rdata !== 32'd0) begin missCount++; $display("[TB] FAIL timeout_rdata: got %h expected 0", resp_rdata); end
        step();
    endtask

    task automatic test_ack_at_timeout();
        issue(1'b0, 32'h0000_0020, 2'b10, 1'b0, 32'h0);
        step();
        step();
        step();
        vecCount++; if (mem_en !== 1'b1) begin missCount++; $display("[TB] FAIL lastcyc_en: got %b expected 1", mem_en); end
        mem_rdata = 32'h1234_5678;
        mem_ack   = 1'b1;
        step();
        mem_ack   = 1'b0;
        vecCount++; if ({resp_valid, resp_err} !== 2'b10) begin missCount++; $display("[TB] FAIL lastcyc_resp: got %b expected 10", {resp_valid, resp_err}); end
        vecCount++; if (resp_rdata !== 32'h1234_5678) begin missCount++; $display("[TB] FAIL lastcyc_rdata: got %h expected 12345678", resp_rdata); end
        step();
    endtask

    task automatic test_reset_mid_access();
        int respSeen = 0;
        issue(1'b1, 32'h0000_0040, 2'b10, 1'b0, 32'hCAFE_F00D);
        vecCount++; if (mem_en !== 1'b1) begin missCount++; $display("[TB] FAIL rst_mid_en_before: got %b expected 1", mem_en); end
        #2 rst_n = 1'b0;
        #1;
        vecCount++; if ({mem_en, mem_we, req_ready} !== 3'b000) begin missCount++; $display("[TB] FAIL rst_mid_async: got %b expected 000", {mem_en, mem_we, req_ready}); end
        vecCount++; if (mem_wdata !== 32'd0) begin missCount++; $display("[TB] FAIL rst_mid_wdata: got %h expected 0", mem_wdata); end
        mem_ack = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid === 1'b1) respSeen++;
            step();
            if (i == 0) begin
                vecCount++; if (req_ready !== 1'b1) begin missCount++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", req_ready); end
            end
        end
        mem_ack = 1'b0;
        vecCount++; if (respSeen != 0) begin missCount++; $display("[TB] FAIL rst_mid_noresp: got %0d expected 0", respSeen); end
        vecCount++; if (mem_en !== 1'b0) begin missCount++; $display("[TB] FAIL rst_mid_en_after: got %b expected 0", mem_en); end
    endtask

    // req_valid stays high through RESP; the second request must wait for IDLE.
    task automatic test_back_to_back();
        issue(1'b1, 32'h0000_0000, 2'b01, 1'b0, 32'h0000_BEEF);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0003;
        req_size  = 2'b00;
        req_wdata = 32'h0000_005A;
        mem_ack   = 1'b1;
        step();
        mem_ack   = 1'b0;
        vecCount++; if ({resp_valid, req_ready} !== 2'b10) begin missCount++; $display("[TB] FAIL b2b_resp: got %b expected 10", {resp_valid, req_ready}); end
        step();
        vecCount++; if ({req_ready, mem_en, resp_valid} !== 3'b100) begin missCount++; $display("[TB] FAIL b2b_idle: got %b expected 100", {req_ready, mem_en, resp_valid}); end
        step();
        req_valid = 1'b0;
        vecCount++; if ({mem_en, mem_sel} !== 5'b1_1000) begin missCount++; $display("[TB] FAIL b2b_sel: got %b expected 11000", {mem_en, mem_sel}); end
        vecCount++; if (mem_wdata !== 32'h5A5A_5A5A) begin missCount++; $display("[TB] FAIL b2b_wdata: got %h expected 5a5a5a5a", mem_wdata); end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        vecCount++; if ({resp_valid, resp_err} !== 2'b10) begin missCount++; $display("[TB] FAIL b2b_resp2: got %b expected 10", {resp_valid, resp_err}); end
        step();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3;
        test_reset();
        test_byte_store();
        test_loads();
        test_misaligned();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
